serial_receiver: RTL

Receive side of the team's one-bit-per-clock serial link. Deserialises frames of start bit (0), DATA_BITS data bits LSB first and one parity bit, sampling `serial_in` on every rising edge of `clk` with no oversampling. It sits opposite the link's transmitter, on the same clock. It delivers each frame as a parallel word with a one-cycle valid strobe and a parity-error flag.

---
 rtl/serial_receiver.sv | 100 ++++++++++
 1 files changed

// File: rtl/serial_receiver.sv
// One-bit-per-clock serial link receiver: start bit (0), DATA_BITS data bits LSB first,
// one parity bit, no stop bit; delivers a parallel word with a one-cycle valid strobe.
module serial_receiver #(
  parameter int unsigned DATA_BITS  = 7,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);
  localparam logic PARITY_INV = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;

  // Each shift bit loads only on the DATA edge whose counter selects it.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
    assign shift_d[gi] = ((state_q == DATA) && (cnt_q == CNT_W'(gi))) ? serial_in
                                                                      : shift_q[gi];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          state_d = PARITY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        // shift_q already holds the bit written on the final DATA edge.
        data_d  = shift_q;
        err_d   = (^shift_q) ^ serial_in ^ PARITY_INV;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = err_q;
  assign busy       = (state_q != IDLE);

  a_valid_single : assert property (@(posedge clk) disable iff (rst) valid |=> !valid);
  a_cnt_range    : assert property (@(posedge clk) disable iff (rst) cnt_q <= LAST_CNT);

endmodule
